sm_matrix_arb_bus: RTL and testbench
====================================

Name: sm_matrix_arb_bus

Overview:
Parametrised successor to the fixed six-slot peripheral matrix. It connects one CPU bus master to N_SLV memory-mapped slaves.
- Address map is defined by per-slave BASE/MASK parameters rather than hard-coded compares.
- Adds a registered request/ready handshake, so slaves may insert wait states.
- Adds a timeout watchdog, an error response for unmapped or timed-out accesses, and error bookkeeping.
- Sits between the core's data port and RAM/GPIO/PWM/ALS/game peripherals.

Parameters:
N_SLV, 6, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
BASE, {default map}, N_SLV*ADDR_W flattened base addresses; slot i at bits [i*ADDR_W +: ADDR_W]
MASK, {default map}, N_SLV*ADDR_W flattened compare masks; slave i hits when (bAddr & MASK_i) == BASE_i
TIMEOUT, 255, ACCESS cycles before forced error; 0 disables the watchdog
TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
bReq  in  1  master request; held with address/data until bReady
bAddr  in  ADDR_W  master address
bWrite  in  1  master write enable
bWData  in  DATA_W  master write data
bRData  out  DATA_W  registered read data
bReady  out  1  one-cycle response strobe
bErr  out  1  error flag, valid with bReady
sSel  out  N_SLV  one-hot slave select
sAddr  out  ADDR_W  latched address to all slaves
sWrite  out  1  latched write enable, gated by any sSel
sWData  out  DATA_W  latched write data
sRData  in  N_SLV*DATA_W  flattened slave read data
sReady  in  N_SLV  per-slave ready
errCount  out  16  saturating count of error responses
errAddr  out  ADDR_W  address of most recent error

Behaviour:
- Reset (async, immediate) clears:
  - state to IDLE
  - sSel, sWrite, bReady, bErr to 0
  - bRData, sAddr, sWData, errAddr, errCount, and the timer to 0
- An assertion of reset mid-access drops sSel in the same cycle. There is no pending write completion.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, bReq=1:
  - latch bAddr, bWrite, bWData
  - decode slaves by priority; the lowest matching index wins
  - on a hit: latch one-hot select, clear timer, go to ACCESS
  - on no hit: set err, bRData=0, go to RESP
- IDLE, bReq=0: stay.
- ACCESS:
  - drive sSel = latched one-hot and sWrite = latched write
  - sample sReady[sel] every cycle:
    - sReady[sel]=1: capture sRData[sel] into bRData (a write captures it too, value don't-care), err=0, go to RESP
    - else timer++; when timer == TIMEOUT (TIMEOUT≠0): err=1, bRData=0, go to RESP
  - sReady and expiry in the same cycle: ready wins, err=0
  - sReady of non-selected slaves is ignored
- RESP:
  - bReady=1 for exactly one cycle with bErr=err; sSel=0
  - on err: errAddr ← latched address; errCount++ saturating at 16'hFFFF
  - always return to IDLE; bReq is ignored in RESP
- Latency, zero-wait slave: request accepted at cycle 0; ACCESS at cycle 1; bReady at cycle 2.
- Throughput: one transfer per 3 cycles. With W wait cycles, bReady comes at cycle 2+W.
- Unmapped address: bReady at cycle 1 with bErr=1.
- bRData holds its value between responses. bErr is 0 whenever bReady=0.
- A master change of bAddr while not in IDLE has no effect, because the values are latched.

Decomposition:
- Shared package sm_matrix_pkg:
  - FSM state localparams
  - default BASE/MASK constants: RAM 0x0000/0xC000, GPIO 0x7F00/0xFFF0, PWM 0x7F10/0xFFF0, ALS 0x7F20/0xFFF0, RACING 0x8000/0xFF00
  - error-data constant (0)
- Sub-module sm_matrix_addr_dec: combinational, parametrised priority decoder.
  - inputs: address, BASE, MASK
  - outputs: one-hot hit vector and a miss flag

Test Plan:
- Read slave 1 (GPIO, 0x7F04), sReady[1] tied high, sRData1=0x12345678: bReady at cycle 2, bRData=0x12345678, bErr=0, sSel=6'b000010 for exactly 1 cycle.
- Write 0xA5A5A5A5 to 0x0000_0010, RAM sReady delayed 3 cycles: sSel[0]=1 and sWrite=1 for 4 cycles, sWData stable, bReady at cycle 5, bErr=0.
- Access 0x0000_9000 (unmapped): no sSel pulse; bReady at cycle 1, bErr=1, bRData=0, errAddr=0x9000, errCount=1.
- Slave 3 never ready, TIMEOUT=4: bReady with bErr=1 after 4 ACCESS cycles; sSel drops in RESP. Repeat with sReady rising on the expiry cycle: bErr=0, read data captured.
- Overlapping map (slave 0 and 2 both match 0x7F10): only sSel[0] asserts.
- Assert reset during ACCESS with errCount=5: sSel=0, bReady=0, and errCount=0 without waiting for a clock edge; the next request after release completes normally.

Source files
------------

// File: rtl/sm_matrix_pkg.sv
// Shared definitions for the sm_matrix bus matrix.
//   state_t   : arbiter FSM states
//   DEF_BASE  : default flattened slave base addresses (6 slots x 32 bits)
//   DEF_MASK  : default flattened slave compare masks (6 slots x 32 bits)
//   ERR_DATA  : read data returned with an error response
package sm_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int DEF_N_SLV  = 6;
  localparam int DEF_ADDR_W = 32;

  // Slot order: 0 RAM, 1 GPIO, 2 PWM, 3 ALS, 4 RACING, 5 spare.
  // The spare slot has a base bit outside its mask, so it can never hit.
  // Upper address bits are included in the masks so aliases above 64K miss.
  localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_BASE = {
    32'h0000_0001, 32'h0000_8000, 32'h0000_7F20,
    32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000
  };

  localparam logic [DEF_N_SLV*DEF_ADDR_W-1:0] DEF_MASK = {
    32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFF0,
    32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000
  };

  localparam int unsigned ERR_DATA = 0;

endpackage

// File: rtl/sm_matrix_addr_dec.sv
// Combinational priority address decoder.
//   addr : address to decode
//   base : flattened per-slave base addresses
//   mask : flattened per-slave compare masks
//   hit  : one-hot hit vector, lowest matching index wins
//   miss : no slave matched
module sm_matrix_addr_dec
  import sm_matrix_pkg::*;
#(
  parameter int N_SLV  = 6,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [N_SLV*ADDR_W-1:0] base,
  input  logic [N_SLV*ADDR_W-1:0] mask,
  output logic [N_SLV-1:0]        hit,
  output logic                    miss
);

  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = 0; i < N_SLV; i++) begin
      if (miss && ((addr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sm_matrix_arb_bus.sv
// Single-master to N_SLV-slave bus matrix with wait states, timeout
// watchdog, error response and error bookkeeping.
//   clk, reset        : clock, asynchronous active-high reset
//   bReq/bAddr/bWrite/bWData : master request, held until bReady
//   bRData/bReady/bErr       : registered read data, response strobe, error
//   sSel/sAddr/sWrite/sWData : one-hot select and latched request to slaves
//   sRData/sReady            : flattened slave read data, per-slave ready
//   errCount/errAddr         : saturating error count, last error address
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for bReq; latches request and decodes address
// ST_ACCESS | selected slave driven; waits for its ready or timeout
// ST_RESP   | one-cycle bReady with bErr; error bookkeeping updated
module sm_matrix_arb_bus
  import sm_matrix_pkg::*;
#(
  parameter int                          N_SLV   = 6,
  parameter int                          ADDR_W  = 32,
  parameter int                          DATA_W  = 32,
  parameter logic [N_SLV*ADDR_W-1:0]     BASE    = DEF_BASE,
  parameter logic [N_SLV*ADDR_W-1:0]     MASK    = DEF_MASK,
  parameter int                          TIMEOUT = 255,
  parameter int                          TO_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bReq,
  input  logic [ADDR_W-1:0]       bAddr,
  input  logic                    bWrite,
  input  logic [DATA_W-1:0]       bWData,
  output logic [DATA_W-1:0]       bRData,
  output logic                    bReady,
  output logic                    bErr,
  output logic [N_SLV-1:0]        sSel,
  output logic [ADDR_W-1:0]       sAddr,
  output logic                    sWrite,
  output logic [DATA_W-1:0]       sWData,
  input  logic [N_SLV*DATA_W-1:0] sRData,
  input  logic [N_SLV-1:0]        sReady,
  output logic [15:0]             errCount,
  output logic [ADDR_W-1:0]       errAddr
);

  localparam logic [TO_W-1:0] TIMEOUT_TC = TO_W'(TIMEOUT);

  state_t              state, state_nxt;
  logic [N_SLV-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [TO_W-1:0]     timer;
  logic [TO_W-1:0]     timer_inc;
  logic                timer_exp;
  logic [15:0]         err_count;
  logic [ADDR_W-1:0]   err_addr;
  logic [N_SLV-1:0]    dec_hit;
  logic                dec_miss;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;

  sm_matrix_addr_dec #(
    .N_SLV  (N_SLV),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr (bAddr),
    .base (BASE),
    .mask (MASK),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | sRData[i*DATA_W +: DATA_W];
    end
  end

  // Only the latched slave's ready is looked at.
  assign sel_ready = |(sReady & sel_q);
  assign timer_inc = timer + 1'b1;
  // The expiring cycle is the TIMEOUT-th ACCESS cycle without ready.
  assign timer_exp = (TIMEOUT != 0) && (timer_inc == TIMEOUT_TC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bReq) state_nxt = dec_miss ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (sel_ready || timer_exp) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timer     <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bReq) begin
            addr_q  <= bAddr;
            write_q <= bWrite;
            wdata_q <= bWData;
            sel_q   <= dec_hit;
            timer   <= '0;
            err_q   <= dec_miss;
            if (dec_miss) rdata_q <= DATA_W'(ERR_DATA);
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            rdata_q <= sel_rdata;
            err_q   <= 1'b0;
          end else if (timer_exp) begin
            rdata_q <= DATA_W'(ERR_DATA);
            err_q   <= 1'b1;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_RESP: begin
          if (err_q) begin
            err_addr <= addr_q;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from the state register so reset drops them at once.
  assign sSel     = (state == ST_ACCESS) ? sel_q : '0;
  assign sWrite   = write_q & (|sSel);
  assign sAddr    = addr_q;
  assign sWData   = wdata_q;
  assign bReady   = (state == ST_RESP);
  assign bErr     = bReady & err_q;
  assign bRData   = rdata_q;
  assign errCount = err_count;
  assign errAddr  = err_addr;

endmodule

// File: tb/tb_sm_matrix_arb_bus.sv
module tb_sm_matrix_arb_bus;

  logic          clk = 1'b0;
  logic          reset;
  logic          bReq;
  logic [31:0]   bAddr;
  logic          bWrite;
  logic [31:0]   bWData;
  logic [31:0]   bRData;
  logic          bReady;
  logic          bErr;
  logic [5:0]    sSel;
  logic [31:0]   sAddr;
  logic          sWrite;
  logic [31:0]   sWData;
  logic [191:0]  sRData;
  logic [5:0]    sReady;
  logic [15:0]   errCount;
  logic [31:0]   errAddr;

  // overlap-map instance
  logic          ov_bReq;
  logic [31:0]   ov_bAddr;
  logic [31:0]   ov_bRData;
  logic          ov_bReady;
  logic          ov_bErr;
  logic [2:0]    ov_sSel;
  logic [31:0]   ov_sAddr;
  logic          ov_sWrite;
  logic [31:0]   ov_sWData;
  logic [15:0]   ov_errCount;
  logic [31:0]   ov_errAddr;

  int n_chk  = 0;
  int n_fail = 0;

  int slv_wait [6];
  int wcnt     [6] = '{default: 0};

  int          r_lat, r_sel_cnt;
  logic        r_sel_bad, r_stray, r_err;
  logic [31:0] r_rdata;
  logic [5:0]  r_resp_sel;

  always #5 clk = ~clk;

  assign sRData = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                   32'h2222_0002, 32'h1234_5678, 32'hDEAD_0000};

  // Slave responder: wait 0 means ready tied high, otherwise ready after
  // that many selected cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) wcnt[i] <= sSel[i] ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    sReady = '0;
    for (int i = 0; i < 6; i++)
      sReady[i] = (slv_wait[i] == 0) || (sSel[i] && (wcnt[i] >= slv_wait[i]));
  end

  sm_matrix_arb_bus #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bReq(bReq), .bAddr(bAddr), .bWrite(bWrite),
    .bWData(bWData), .bRData(bRData), .bReady(bReady), .bErr(bErr),
    .sSel(sSel), .sAddr(sAddr), .sWrite(sWrite), .sWData(sWData),
    .sRData(sRData), .sReady(sReady), .errCount(errCount), .errAddr(errAddr)
  );

  sm_matrix_arb_bus #(
    .N_SLV(3),
    .BASE({32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000}),
    .MASK({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000}),
    .TIMEOUT(4)
  ) dut_ovl (
    .clk(clk), .reset(reset), .bReq(ov_bReq), .bAddr(ov_bAddr), .bWrite(1'b0),
    .bWData(32'h0), .bRData(ov_bRData), .bReady(ov_bReady), .bErr(ov_bErr),
    .sSel(ov_sSel), .sAddr(ov_sAddr), .sWrite(ov_sWrite), .sWData(ov_sWData),
    .sRData({32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}), .sReady(3'b111),
    .errCount(ov_errCount), .errAddr(ov_errAddr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request starting at posedge+1 and follows it to bReady.
  // The master bus is scrambled after acceptance to show it is latched.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [5:0] exp_sel);
    bAddr = a; bWrite = wr; bWData = wd; bReq = 1'b1;
    r_lat = 0; r_sel_cnt = 0; r_sel_bad = 1'b0; r_stray = 1'b0;
    do begin
      @(posedge clk); #1;
      r_lat++;
      if (r_lat == 1) begin bAddr = ~a; bWrite = ~wr; bWData = ~wd; end
      if (sSel != '0) begin
        r_sel_cnt++;
        if (sSel !== exp_sel || sWrite !== wr || sAddr !== a || sWData !== wd)
          r_sel_bad = 1'b1;
      end
      if (!bReady && bErr) r_stray = 1'b1;
    end while (!bReady && r_lat < 40);
    chk("bready_seen", 64'(bReady), 64'd1);
    r_err = bErr; r_rdata = bRData; r_resp_sel = sSel;
    bReq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_xfer(input string tag, input int lat, input int sel_cnt,
                          input logic err, input logic [31:0] rdata);
    chk({tag, "_lat"},      64'(r_lat), 64'(lat));
    chk({tag, "_selcnt"},   64'(r_sel_cnt), 64'(sel_cnt));
    chk({tag, "_selbad"},   64'(r_sel_bad), 64'd0);
    chk({tag, "_stray"},    64'(r_stray), 64'd0);
    chk({tag, "_respsel"},  64'(r_resp_sel), 64'd0);
    chk({tag, "_err"},      64'(r_err), 64'(err));
    chk({tag, "_rdata"},    64'(r_rdata), 64'(rdata));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    slv_wait = '{0, 0, 0, 1000, 0, 0};
    reset = 1'b1; bReq = 1'b0; bAddr = '0; bWrite = 1'b0; bWData = '0;
    ov_bReq = 1'b0; ov_bAddr = '0;
    #2;
    chk("rst_bready",   64'(bReady), 64'd0);
    chk("rst_berr",     64'(bErr), 64'd0);
    chk("rst_ssel",     64'(sSel), 64'd0);
    chk("rst_swrite",   64'(sWrite), 64'd0);
    chk("rst_brdata",   64'(bRData), 64'd0);
    chk("rst_saddr",    64'(sAddr), 64'd0);
    chk("rst_errcount", 64'(errCount), 64'd0);
    chk("rst_erraddr",  64'(errAddr), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // GPIO read, zero wait
    xfer(32'h0000_7F04, 1'b0, 32'h0, 6'b000010);
    chk_xfer("gpio_rd", 2, 1, 1'b0, 32'h1234_5678);
    chk("gpio_rdata_hold", 64'(bRData), 64'h1234_5678);

    // RAM write, 3 wait cycles
    slv_wait[0] = 3;
    xfer(32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 6'b000001);
    chk_xfer("ram_wr", 5, 4, 1'b0, 32'hDEAD_0000);

    // unmapped
    xfer(32'h0000_9000, 1'b0, 32'h0, 6'b000000);
    chk_xfer("unmap", 1, 0, 1'b1, 32'h0);
    chk("unmap_erraddr",  64'(errAddr), 64'h9000);
    chk("unmap_errcount", 64'(errCount), 64'd1);

    // ALS never ready: timeout after 4 ACCESS cycles
    xfer(32'h0000_7F24, 1'b0, 32'h0, 6'b001000);
    chk_xfer("als_to", 5, 4, 1'b1, 32'h0);
    chk("als_to_erraddr",  64'(errAddr), 64'h7F24);
    chk("als_to_errcount", 64'(errCount), 64'd2);

    // ALS ready on the expiry cycle: ready wins
    slv_wait[3] = 3;
    xfer(32'h0000_7F20, 1'b0, 32'h0, 6'b001000);
    chk_xfer("als_edge", 5, 4, 1'b0, 32'h3333_0003);
    chk("als_edge_errcount", 64'(errCount), 64'd2);

    // RACING read
    xfer(32'h0000_80FC, 1'b0, 32'h0, 6'b010000);
    chk_xfer("race_rd", 2, 1, 1'b0, 32'h4444_0004);

    // three more misses: upper bits set, map gaps
    xfer(32'h0001_0000, 1'b0, 32'h0, 6'b000000);
    chk("miss_hi_err", 64'(r_err), 64'd1);
    xfer(32'h0000_7F30, 1'b0, 32'h0, 6'b000000);
    chk("miss_gap_err", 64'(r_err), 64'd1);
    xfer(32'h0000_8100, 1'b1, 32'h1, 6'b000000);
    chk("miss_race_err", 64'(r_err), 64'd1);
    chk("miss_errcount", 64'(errCount), 64'd5);
    chk("miss_erraddr",  64'(errAddr), 64'h8100);

    // overlapping map: slot 0 and slot 2 both match, slot 0 wins
    ov_bAddr = 32'h0000_7F10; ov_bReq = 1'b1;
    @(posedge clk); #1;
    chk("ovl_ssel", 64'(ov_sSel), 64'b001);
    ov_bReq = 1'b0;
    @(posedge clk); #1;
    chk("ovl_bready", 64'(ov_bReady), 64'd1);
    chk("ovl_rdata",  64'(ov_bRData), 64'hAAAA_0000);
    chk("ovl_berr",   64'(ov_bErr), 64'd0);
    @(posedge clk); #1;

    // reset in the middle of an ACCESS
    slv_wait[3] = 1000;
    bAddr = 32'h0000_7F28; bWrite = 1'b0; bReq = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_ssel", 64'(sSel), 64'b001000);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ssel",     64'(sSel), 64'd0);
    chk("async_rst_bready",   64'(bReady), 64'd0);
    chk("async_rst_errcount", 64'(errCount), 64'd0);
    bReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    xfer(32'h0000_7F08, 1'b0, 32'h0, 6'b000010);
    chk_xfer("post_rst", 2, 1, 1'b0, 32'h1234_5678);
    chk("post_rst_errcount", 64'(errCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
